// File: rtl/store_retire_buffer.sv
// Post-retirement store buffer: in-order FIFO of committed stores draining to memory,
// with youngest-match store-to-load forwarding / conflict detection for loads.
module store_retire_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [ADDR_W-1:0]          in_addr,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [1:0]                 in_size,
   output logic                       in_ready,
   output logic                       mem_req_valid,
   output logic [ADDR_W-1:0]          mem_req_addr,
   output logic [DATA_W-1:0]          mem_req_data,
   output logic [1:0]                 mem_req_size,
   input  logic                       mem_req_ready,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       ld_hit,
   output logic [DATA_W-1:0]          ld_data,
   output logic                       ld_conflict,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic              valid_reg [DEPTH];
   logic [ADDR_W-1:0] addr_reg  [DEPTH];
   logic [DATA_W-1:0] data_reg  [DEPTH];
   logic [1:0]        size_reg  [DEPTH];

   logic [PTR_W-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             push, pop;

   logic [DEPTH-1:0] overlap;
   logic             fwd_found;
   logic [PTR_W-1:0] fwd_idx, scan_idx;
   logic             ld_addr_unused;

   assign in_ready      = (count_reg < CNT_W'(DEPTH));
   assign empty         = (count_reg == '0);
   assign count         = count_reg;
   assign mem_req_valid = !empty;
   assign mem_req_addr  = addr_reg[head_reg];
   assign mem_req_data  = data_reg[head_reg];
   assign mem_req_size  = size_reg[head_reg];

   assign push = in_valid && in_ready;
   assign pop  = mem_req_valid && mem_req_ready;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         for (int i = 0; i < DEPTH; i++) valid_reg[i] <= 1'b0;
      end else begin
         count_reg <= count_next;
         if (push) begin
            valid_reg[tail_reg] <= 1'b1;
            addr_reg[tail_reg]  <= in_addr;
            data_reg[tail_reg]  <= in_data;
            size_reg[tail_reg]  <= in_size;
            tail_reg            <= tail_reg + 1'b1;
         end
         // Push and pop never target the same slot: that needs full (push refused) or empty (no pop).
         if (pop) begin
            valid_reg[head_reg] <= 1'b0;
            head_reg            <= head_reg + 1'b1;
         end
      end
   end

   // Word-granular overlap; the low two address bits never affect the match.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_overlap
      assign overlap[gi] = valid_reg[gi] &&
                           (addr_reg[gi][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
   end
   assign ld_addr_unused = &{1'b0, ld_addr[1:0]};

   // Scan from tail (oldest slot when full) towards tail-1; the last match is the youngest.
   always_comb begin
      fwd_found = 1'b0;
      fwd_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = tail_reg + PTR_W'(k);
         if (overlap[scan_idx]) begin
            fwd_found = 1'b1;
            fwd_idx   = scan_idx;
         end
      end
   end

   assign ld_hit      = fwd_found && size_reg[fwd_idx][1];
   assign ld_conflict = fwd_found && !size_reg[fwd_idx][1];
   assign ld_data     = ld_hit ? data_reg[fwd_idx] : '0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (count_reg <= CNT_W'(DEPTH));
         assert (!(pop && count_reg == '0));
      end
   end
endmodule

// File: tb/tb_store_retire_buffer.sv
// Directed bench for store_retire_buffer: handshakes, ordering, full/empty edges,
// forwarding priority and reset discard.
module tb_store_retire_buffer;
   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [1:0]  in_size;
   logic        in_ready;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic [1:0]  mem_req_size;
   logic        mem_req_ready;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        ld_conflict;
   logic [2:0]  count;
   logic        empty;

   int checks = 0;
   int errors = 0;

   logic [31:0] q_addr [$];
   logic [31:0] q_data [$];
   int          model_count;
   int          next_item;
   int          cycles;
   logic        exp_push, exp_pop;

   always #5 clock = ~clock;

   store_retire_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
      .in_ready(in_ready),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_size(mem_req_size),
      .mem_req_ready(mem_req_ready),
      .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
      .count(count), .empty(empty)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; in_size = 2'b10;
      mem_req_ready = 1'b0; ld_addr = '0;
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_valid", mem_req_valid, 0);
      chk("rst_ld_hit", ld_hit, 0);
      chk("rst_ld_conflict", ld_conflict, 0);
      chk("rst_ld_data", ld_data, 0);

      // 1: single word store, memory always ready; no same-cycle bypass
      in_valid = 1'b1; in_addr = 32'h100; in_data = 32'hDEADBEEF; in_size = 2'b10;
      mem_req_ready = 1'b1;
      #1;
      chk("t1_no_bypass", mem_req_valid, 0);
      step();
      in_valid = 1'b0;
      #1;
      chk("t1_valid", mem_req_valid, 1);
      chk("t1_addr", mem_req_addr, 32'h100);
      chk("t1_data", mem_req_data, 32'hDEADBEEF);
      chk("t1_size", mem_req_size, 2'b10);
      step();
      chk("t1_empty", empty, 1);
      chk("t1_valid_drop", mem_req_valid, 0);

      // 2: fill with memory stalled, refuse a 5th, drain in order
      mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_addr = 32'h400 + 32'(4 * i); in_data = 32'hA0 + 32'(i);
         step();
      end
      in_valid = 1'b0;
      #1;
      chk("t2_count_full", count, 4);
      chk("t2_in_ready_full", in_ready, 0);
      in_valid = 1'b1; in_addr = 32'h500; in_data = 32'h55;
      step();
      in_valid = 1'b0;
      #1;
      chk("t2_count_after_5th", count, 4);
      chk("t2_head_stable", mem_req_addr, 32'h400);
      mem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2_drain_valid", mem_req_valid, 1);
         chk("t2_drain_addr", mem_req_addr, 32'h400 + 32'(4 * i));
         chk("t2_drain_data", mem_req_data, 32'hA0 + 32'(i));
         step();
      end
      chk("t2_empty", empty, 1);
      mem_req_ready = 1'b0;

      // 3: push+pop while full (push refused) and while not full (count holds)
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_addr = 32'h600 + 32'(4 * i); in_data = 32'hB0 + 32'(i);
         step();
      end
      in_addr = 32'h700; in_data = 32'h77; mem_req_ready = 1'b1;
      step();
      in_valid = 1'b0; mem_req_ready = 1'b0;
      #1;
      chk("t3_full_pp_count", count, 3);
      chk("t3_full_pp_head", mem_req_addr, 32'h604);
      in_valid = 1'b1; in_addr = 32'h710; in_data = 32'h71; mem_req_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #1;
      chk("t3_pp_count", count, 3);
      chk("t3_pp_head", mem_req_addr, 32'h608);
      step();
      chk("t3_drain1", mem_req_addr, 32'h60C);
      step();
      chk("t3_drain2_addr", mem_req_addr, 32'h710);
      chk("t3_drain2_data", mem_req_data, 32'h71);
      step();
      chk("t3_empty", empty, 1);
      mem_req_ready = 1'b0;

      // 4: youngest of two word stores to the same word wins
      in_valid = 1'b1; in_addr = 32'h200; in_data = 32'h11111111; in_size = 2'b10;
      step();
      in_data = 32'h22222222;
      step();
      in_valid = 1'b0; ld_addr = 32'h202;
      #1;
      chk("t4_hit", ld_hit, 1);
      chk("t4_data", ld_data, 32'h22222222);
      chk("t4_conflict", ld_conflict, 0);
      mem_req_ready = 1'b1;
      step();
      // last entry is being popped this cycle but still forwards
      chk("t4_pop_cycle_hit", ld_hit, 1);
      chk("t4_pop_cycle_data", ld_data, 32'h22222222);
      step();
      chk("t4_empty_no_hit", ld_hit, 0);
      mem_req_ready = 1'b0;

      // 5: younger byte store over an older word store forces a conflict
      in_valid = 1'b1; in_addr = 32'h300; in_data = 32'h33333333; in_size = 2'b10;
      step();
      in_addr = 32'h301; in_data = 32'h44; in_size = 2'b00;
      step();
      in_valid = 1'b0; in_size = 2'b10; ld_addr = 32'h300;
      #1;
      chk("t5_conflict", ld_conflict, 1);
      chk("t5_no_hit", ld_hit, 0);
      ld_addr = 32'h304;
      #1;
      chk("t5_miss_hit", ld_hit, 0);
      chk("t5_miss_conflict", ld_conflict, 0);
      chk("t5_miss_data", ld_data, 0);
      mem_req_ready = 1'b1;
      step(); step();
      chk("t5_empty", empty, 1);

      // 6: ten stores through the wrapping pointers with ready toggling
      model_count = 0; next_item = 0; cycles = 0;
      while ((next_item < 10 || q_addr.size() > 0) && cycles < 60) begin
         in_valid = (next_item < 10);
         in_addr = 32'h800 + 32'(4 * next_item);
         in_data = 32'hC0 + 32'(next_item);
         mem_req_ready = cycles[0];
         #1;
         chk("t6_in_ready", in_ready, (model_count < 4) ? 1 : 0);
         chk("t6_count", count, 64'(model_count));
         if (q_addr.size() > 0) begin
            chk("t6_head_addr", mem_req_addr, q_addr[0]);
            chk("t6_head_data", mem_req_data, q_data[0]);
         end
         exp_push = in_valid && (model_count < 4);
         exp_pop  = mem_req_ready && (q_addr.size() > 0);
         step();
         if (exp_pop) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            model_count--;
         end
         if (exp_push) begin
            q_addr.push_back(32'h800 + 32'(4 * next_item));
            q_data.push_back(32'hC0 + 32'(next_item));
            model_count++;
            next_item++;
         end
         cycles++;
      end
      in_valid = 1'b0;
      chk("t6_finished_in_budget", (cycles < 60) ? 1 : 0, 1);
      #1;
      chk("t6_empty", empty, 1);

      // 6b: reset discards a head stuck waiting for memory
      mem_req_ready = 1'b0;
      in_valid = 1'b1; in_addr = 32'h900; in_data = 32'h99;
      step();
      in_addr = 32'h904;
      step();
      in_valid = 1'b0;
      #1;
      chk("t6b_pending", mem_req_valid, 1);
      reset = 1'b1; mem_req_ready = 1'b1;
      step();
      reset = 1'b0; mem_req_ready = 1'b0; ld_addr = 32'h900;
      #1;
      chk("t6b_valid", mem_req_valid, 0);
      chk("t6b_count", count, 0);
      chk("t6b_empty", empty, 1);
      chk("t6b_in_ready", in_ready, 1);
      chk("t6b_ld_hit", ld_hit, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
